// File: rtl/pm_page_writer.sv
// Page-programming engine: buffers one PM page from the SPM path, then erases and/or programs it.
// Optional read-back verify of the programmed page is compiled in with PM_WRITER_VERIFY_EN.
module pm_page_writer #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned PAGE_W    = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [WORD_SIZE-1:0]     word_i,
  input  logic [PAGE_W-1:0]        off_i,
  input  logic                     fill_i,
  input  logic [ADDR_W-PAGE_W-1:0] page_i,
  input  logic                     erase_i,
  input  logic                     commit_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [ADDR_W-1:0]        pm_addr_o,
  output logic [WORD_SIZE-1:0]     pm_data_o,
  output logic                     pm_we_o,
  input  logic [WORD_SIZE-1:0]     pm_data_i
);

  localparam int unsigned Words = 2 ** PAGE_W;
  localparam int unsigned PnW   = ADDR_W - PAGE_W;

  localparam logic [WORD_SIZE-1:0] Ones  = {WORD_SIZE{1'b1}};
  localparam logic [PAGE_W-1:0]    LastK = {PAGE_W{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StErase,
    StWrite,
    StVerify,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [PAGE_W-1:0]      k_q, k_d;
  logic [PnW-1:0]         page_q, page_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [Words-1:0]       valid_q, valid_d;
  logic [WORD_SIZE-1:0]   buf_mem [Words];

  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pm_we_q, pm_we_d;
  logic [ADDR_W-1:0]      pm_addr_q, pm_addr_d;
  logic [WORD_SIZE-1:0]   pm_data_q, pm_data_d;

  logic                   accept;
  logic                   fill_ok;
  logic                   last_k;
  logic                   write_end;
  logic                   vtail_d;
  logic [WORD_SIZE-1:0]   wr_word;

  assign accept    = (state_q == StIdle) && (erase_i || commit_i);
  assign fill_ok   = fill_i && !busy_q;
  assign last_k    = (k_q == LastK);
  assign write_end = (state_q == StWrite) && last_k;

`ifdef PM_WRITER_VERIFY_EN
  logic                 vtail_q;
  logic [Words-1:0]     snap_q, snap_d;
  logic                 cmp_vld_q, cmp_vld_d;
  logic [PAGE_W-1:0]    cmp_k_q, cmp_k_d;
  logic                 err_q, err_d;
  logic [WORD_SIZE-1:0] exp_word;
`endif

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    page_d    = page_q;
    wr_pend_d = wr_pend_q;
    vtail_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (erase_i) begin
          state_d   = StErase;
          k_d       = '0;
          page_d    = page_i;
          wr_pend_d = commit_i;
        end else if (commit_i) begin
          state_d   = StWrite;
          k_d       = '0;
          page_d    = page_i;
          wr_pend_d = 1'b0;
        end
      end
      StErase: begin
        k_d = k_q + 1'b1;
        if (last_k) begin
          state_d = wr_pend_q ? StWrite : StDone;
        end
      end
      StWrite: begin
        k_d = k_q + 1'b1;
        if (last_k) begin
`ifdef PM_WRITER_VERIFY_EN
          state_d = StVerify;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef PM_WRITER_VERIFY_EN
      // One extra tail cycle waits out the PM read latency for the last address.
      StVerify: begin
        if (vtail_q) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + 1'b1;
          vtail_d = last_k;
        end
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A fill landing in the same cycle as the command is forwarded into the first write.
  always_comb begin
    wr_word = valid_q[k_d] ? buf_mem[k_d] : Ones;
    if (fill_ok && (off_i == k_d)) begin
      wr_word = word_i;
    end
  end

  // Registered outputs decoded from the next state
  always_comb begin
    pm_addr_d = pm_addr_q;
    pm_data_d = pm_data_q;
    pm_we_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = (state_d == StDone);
    case (state_d)
      StErase: begin
        busy_d    = 1'b1;
        pm_we_d   = 1'b1;
        pm_addr_d = {page_d, k_d};
        pm_data_d = Ones;
      end
      StWrite: begin
        busy_d    = 1'b1;
        pm_we_d   = 1'b1;
        pm_addr_d = {page_d, k_d};
        pm_data_d = wr_word;
      end
      StVerify: begin
        busy_d = 1'b1;
        if (!vtail_d) begin
          pm_addr_d = {page_d, k_d};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_ok) begin
      valid_d[off_i] = 1'b1;
    end
    if (write_end) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      k_q       <= '0;
      page_q    <= '0;
      wr_pend_q <= 1'b0;
      valid_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pm_we_q   <= 1'b0;
      pm_addr_q <= '0;
      pm_data_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      page_q    <= page_d;
      wr_pend_q <= wr_pend_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pm_we_q   <= pm_we_d;
      pm_addr_q <= pm_addr_d;
      pm_data_q <= pm_data_d;
    end
  end

  // Buffer storage needs no reset; the valid bits gate its contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i && fill_ok) begin
      buf_mem[off_i] <= word_i;
    end
  end

`ifdef PM_WRITER_VERIFY_EN
  // The valid bits clear as WRITE ends, so keep a copy for the read-back comparison.
  assign exp_word = snap_q[cmp_k_q] ? buf_mem[cmp_k_q] : Ones;

  always_comb begin
    snap_d    = write_end ? valid_q : snap_q;
    cmp_vld_d = (state_q == StVerify) && !vtail_q;
    cmp_k_d   = k_q;
    err_d     = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (cmp_vld_q && (pm_data_i != exp_word)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vtail_q   <= 1'b0;
      snap_q    <= '0;
      cmp_vld_q <= 1'b0;
      cmp_k_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      vtail_q   <= vtail_d;
      snap_q    <= snap_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_k_q   <= cmp_k_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_pm_data;
  assign unused_pm_data = ^pm_data_i;
  assign err_o          = 1'b0;
`endif

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign pm_we_o   = pm_we_q;
  assign pm_addr_o = pm_addr_q;
  assign pm_data_o = pm_data_q;

endmodule
